// File: rtl/rf_write_arbiter.sv
// Single owner of the register-file write port: merges in-order pipeline WB writes
// with buffered multi-cycle results, bounding how long a buffered result can starve.
module rf_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_we,
  input  logic [4:0]                    pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  output logic                          pipe_stall,
  input  logic                          mc_valid,
  output logic                          mc_ready,
  input  logic [4:0]                    mc_rd,
  input  logic [XLEN-1:0]               mc_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [31:0]                   pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [4:0]            rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0]       data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_vld;
  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         count, count_nxt;
  logic [WW-1:0]         wait_cnt;

  logic pv, fne, gf, gp, push, pop;

  // Writes to x0 are architectural no-ops, so they neither compete nor occupy the FIFO.
  assign pv         = pipe_we && (pipe_rd != 5'd0);
  assign fne        = (count != '0);
  assign gf         = fne && (!pv || (wait_cnt == WW'(MAX_WAIT)));
  assign gp         = pv && !gf;
  assign pipe_stall = pv && gf;
  assign push       = mc_valid && mc_ready && (mc_rd != 5'd0);
  assign pop        = gf;
  assign fifo_count = count;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pending mask is derived from per-slot valid bits so stale slot contents never leak.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld[i]) pend_mask[rd_mem[i]] = 1'b1;
    end
  end

  // Stage: FIFO storage (payload only, occupancy tracked by slot_vld)
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      rd_mem[wptr]   <= mc_rd;
      data_mem[wptr] <= mc_data;
    end
  end

  // Stage: FIFO control, starvation counter and register-file write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      mc_ready <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      wait_cnt <= '0;
      slot_vld <= '0;
    end else begin
      // Ready follows next-cycle occupancy, so it reopens the cycle after a pop.
      mc_ready <= (count_nxt != CW'(FIFO_DEPTH));
      count    <= count_nxt;
      if (pop) begin
        rptr           <= rptr + AW'(1);
        slot_vld[rptr] <= 1'b0;
      end
      if (push) begin
        wptr           <= wptr + AW'(1);
        slot_vld[wptr] <= 1'b1;
      end
      if (fne && !gf) begin
        if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (gp) begin
        rf_we    <= 1'b1;
        rf_rd    <= pipe_rd;
        rf_wdata <= pipe_data;
      end else if (gf) begin
        rf_we    <= 1'b1;
        rf_rd    <= rd_mem[rptr];
        rf_wdata <= data_mem[rptr];
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected register-file writes are queued as
// stimulus is driven and checked in order whenever rf_we is observed.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [1:0]  fifo_count;

  int  n_chk = 0;
  int  n_err = 0;
  wr_t sb[$];
  wr_t mon_e;

  rf_write_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.rd   = r;
    w.data = d;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every observed write must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (rf_we === 1'b1) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rf_rd", rf_rd, mon_e.rd);
        chk("rf_wdata", rf_wdata, mon_e.data);
      end
    end
  end

  initial begin
    int pi;
    int mi;
    int fi;
    logic [11:0] stall_pat;
    logic [11:0] ready_pat;
    rst_n = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
    tick(); tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_mc_ready", mc_ready, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_pend_mask", pend_mask, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", mc_ready, 1);

    // Pipeline write with empty FIFO: one-cycle latency, no stall.
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    sb.push_back(mk(5'd5, 32'hDEADBEEF));
    #1 chk("t1_stall", pipe_stall, 0);
    tick();
    chk("t1_rf_we", rf_we, 1);
    pipe_we = 1'b0;

    // mc result into empty FIFO: pending one cycle, written two cycles after accept.
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h12;
    sb.push_back(mk(5'd7, 32'h12));
    #1 chk("t2_ready", mc_ready, 1);
    tick();
    mc_valid = 1'b0;
    #1;
    chk("t2_pend", pend_mask, 32'h1 << 7);
    chk("t2_count", fifo_count, 1);
    chk("t2_no_we_yet", rf_we, 0);
    tick();
    chk("t2_rf_we", rf_we, 1);
    chk("t2_pend_clear", pend_mask, 0);
    chk("t2_count_empty", fifo_count, 0);

    // Starvation bound: pipeline wins four cycles, then the buffered rd=9 is forced out.
    for (int k = 0; k < 7; k++) begin
      pipe_we   = 1'b1;
      pipe_rd   = (k == 6) ? 5'd6 : 5'(k + 1);
      pipe_data = (k == 6) ? 32'h105 : 32'h100 + k;
      mc_valid  = (k == 0);
      mc_rd     = 5'd9;
      mc_data   = 32'h900;
      #1 chk("t3_stall", pipe_stall, (k == 5));
      if (k == 3) chk("t3_pend9", pend_mask[9], 1);
      if (k == 5)      sb.push_back(mk(5'd9, 32'h900));
      else if (k == 6) sb.push_back(mk(5'd6, 32'h105));
      else             sb.push_back(mk(5'(k + 1), 32'h100 + k));
      tick();
    end
    pipe_we = 1'b0; mc_valid = 1'b0;
    #1 chk("t3_count", fifo_count, 0);

    // Backpressure with a saturating pipeline and a held mc stream of rd 10,11,12.
    stall_pat = (12'd1 << 5) | (12'd1 << 10);
    ready_pat = (12'd1 << 0) | (12'd1 << 1) | (12'd1 << 6) | (12'd1 << 11);
    pi = 0; mi = 0; fi = 0;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      pipe_we   = 1'b1;
      pipe_rd   = 5'(1 + pi);
      pipe_data = 32'h4000_0000 + pi;
      mc_valid  = (mi < 3);
      mc_rd     = 5'(10 + mi);
      mc_data   = 32'hC000_0000 + 10 + mi;
      #1;
      chk("t4_stall", pipe_stall, stall_pat[c]);
      chk("t4_ready", mc_ready, ready_pat[c]);
      if (c == 2) chk("t4_count_full", fifo_count, 2);
      if (stall_pat[c]) begin
        sb.push_back(mk(5'(10 + fi), 32'hC000_0000 + 10 + fi));
        fi++;
      end else begin
        sb.push_back(mk(5'(1 + pi), 32'h4000_0000 + pi));
      end
      acc = mc_valid && mc_ready;
      tick();
      if (!stall_pat[c]) pi++;
      if (acc) mi++;
    end
    pipe_we = 1'b0; mc_valid = 1'b0;
    sb.push_back(mk(5'd12, 32'hC000_000C));
    #1 chk("t4_pend12", pend_mask, 32'h1 << 12);
    tick();
    chk("t4_drain_we", rf_we, 1);
    chk("t4_drain_count", fifo_count, 0);

    // x0 filtering: rd=0 pipeline never stalls, rd=0 mc handshake completes unbuffered.
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hBAD0;
    mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h33;
    tick();
    mc_rd = 5'd0; mc_data = 32'hBAD1;
    sb.push_back(mk(5'd3, 32'h33));
    #1;
    chk("t5_stall", pipe_stall, 0);
    chk("t5_ready", mc_ready, 1);
    tick();
    chk("t5_count", fifo_count, 0);
    chk("t5_pend", pend_mask, 0);
    tick();
    chk("t5_no_we", rf_we, 0);
    chk("t5_ready_after", mc_ready, 1);
    pipe_we = 1'b0; mc_valid = 1'b0;

    // Reset with two buffered entries discards them and issues no write.
    pipe_we = 1'b1; pipe_rd = 5'd25; pipe_data = 32'h2500;
    mc_valid = 1'b1; mc_rd = 5'd21; mc_data = 32'h2100;
    sb.push_back(mk(5'd25, 32'h2500));
    tick();
    pipe_rd = 5'd26; pipe_data = 32'h2600;
    mc_rd = 5'd22; mc_data = 32'h2200;
    sb.push_back(mk(5'd26, 32'h2600));
    tick();
    mc_valid = 1'b0;
    pipe_rd = 5'd27; pipe_data = 32'h2700;
    #1;
    chk("t6_count_full", fifo_count, 2);
    chk("t6_pend", pend_mask, (32'h1 << 21) | (32'h1 << 22));
    rst_n = 1'b0;
    tick();
    chk("t6_rst_we", rf_we, 0);
    chk("t6_rst_ready", mc_ready, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_pend", pend_mask, 0);
    rst_n = 1'b1;
    pipe_rd = 5'd28; pipe_data = 32'h2800;
    sb.push_back(mk(5'd28, 32'h2800));
    #1 chk("t6_stall", pipe_stall, 0);
    tick();
    chk("t6_resume_we", rf_we, 1);
    chk("t6_resume_ready", mc_ready, 1);
    pipe_we = 1'b0;
    tick();
    chk("t6_idle_we", rf_we, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
